// File: rtl/parallax_sequencer.sv
// rtl/parallax_sequencer.sv - VGA timing, frame sequencing and per-layer scroll offsets
// Optional vblank interrupt is built only when PARALLAX_SEQ_IRQ_EN is defined.
module parallax_sequencer #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 1,
  parameter int LAYERS   = 4,
  parameter int SCROLL_W = 10
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        enable,
  input  logic                                        cfg_we,
  input  logic [(LAYERS > 1 ? $clog2(LAYERS) : 1)-1:0] cfg_addr,
  input  logic [3:0]                                  cfg_wdata,
  output logic                                        pix_en,
  output logic [9:0]                                  px_x,
  output logic [9:0]                                  px_y,
  output logic                                        hsync,
  output logic                                        vsync,
  output logic                                        active,
  output logic                                        frame_start,
  output logic [LAYERS*SCROLL_W-1:0]                  scroll,
  output logic                                        irq,
  input  logic                                        irq_ack
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] X_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] X_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] Y_ACT    = 10'(V_ACTIVE);

  logic [DW-1:0]       div_q, div_d;
  logic                pix_en_q, pix_en_d;
  logic [9:0]          x_q, x_d, y_q, y_d;
  logic                hs_q, hs_d, vs_q, vs_d, act_q, act_d, fs_q, fs_d;
  logic                irq_q, irq_d;
  logic [3:0]          speed_q  [LAYERS];
  logic [SCROLL_W-1:0] scroll_q [LAYERS];
  logic [SCROLL_W-1:0] scroll_d [LAYERS];
  logic                adv, line_end, frame_end;

  // pix_en_q marks the cycle whose closing edge advances the counters,
  // so sync/active decode from the next-count values stays aligned with px_x/px_y.
  always_comb begin
    div_d     = '0;
    pix_en_d  = 1'b0;
    x_d       = '0;
    y_d       = '0;
    adv       = enable && pix_en_q;
    line_end  = (x_q == X_LAST);
    frame_end = adv && line_end && (y_q == Y_LAST);
    if (enable) begin
      div_d    = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
      pix_en_d = (div_d == DIV_LAST);
      x_d      = x_q;
      y_d      = y_q;
      if (adv) begin
        if (line_end) begin
          x_d = '0;
          y_d = (y_q == Y_LAST) ? '0 : y_q + 10'd1;
        end else begin
          x_d = x_q + 10'd1;
        end
      end
    end
    hs_d  = !((x_d >= HS_START) && (x_d < HS_END));
    vs_d  = !((y_d >= VS_START) && (y_d < VS_END));
    act_d = (x_d < X_ACT) && (y_d < Y_ACT);
    fs_d  = frame_end;
  end

  always_comb begin
    for (int i = 0; i < LAYERS; i++) begin
      scroll_d[i] = scroll_q[i];
      if (frame_end) begin
        scroll_d[i] = scroll_q[i] + SCROLL_W'($signed(speed_q[i]));
      end
    end
  end

`ifdef PARALLAX_SEQ_IRQ_EN
  localparam logic [9:0] Y_IRQ_PREV = 10'(V_ACTIVE + V_FP - 1);
  logic irq_set;
  always_comb begin
    irq_set = adv && line_end && (y_q == Y_IRQ_PREV);
    irq_d   = irq_set || (irq_q && !irq_ack);
  end
`else
  logic irq_ack_unused;
  assign irq_ack_unused = irq_ack;
  assign irq_d          = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q    <= '0;
      pix_en_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      act_q    <= 1'b1;
      fs_q     <= 1'b0;
      irq_q    <= 1'b0;
      for (int i = 0; i < LAYERS; i++) begin
        speed_q[i]  <= '0;
        scroll_q[i] <= '0;
      end
    end else begin
      div_q    <= div_d;
      pix_en_q <= pix_en_d;
      x_q      <= x_d;
      y_q      <= y_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      act_q    <= act_d;
      fs_q     <= fs_d;
      irq_q    <= irq_d;
      for (int i = 0; i < LAYERS; i++) begin
        scroll_q[i] <= scroll_d[i];
      end
      if (cfg_we && (32'(cfg_addr) < LAYERS)) begin
        speed_q[cfg_addr] <= cfg_wdata;
      end
    end
  end

  for (genvar g = 0; g < LAYERS; g++) begin : g_scroll
    assign scroll[g*SCROLL_W +: SCROLL_W] = scroll_q[g];
  end

  assign pix_en      = pix_en_q;
  assign px_x        = x_q;
  assign px_y        = y_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign active      = act_q;
  assign frame_start = fs_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_parallax_sequencer.sv
// tb/tb_parallax_sequencer.sv - randomized check of parallax_sequencer against a pixel-count model
// Two instances (CLK_DIV 1 and 2) run on shrunken timings so several frames fit in a short run.
module tb_parallax_sequencer;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6, VF = 2, VS = 1, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int LAYERS = 4, SW = 10;

  logic clk = 1'b0;
  logic reset, enable, cfg_we, irq_ack;
  logic [1:0] cfg_addr;
  logic [3:0] cfg_wdata;
  logic [1:0] pe_o, hs_o, vs_o, act_o, fs_o, irq_o;
  logic [9:0] x_o [2];
  logic [9:0] y_o [2];
  logic [LAYERS*SW-1:0] sc_o [2];

  always #5 clk = ~clk;

  parallax_sequencer #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CLK_DIV(1),
    .LAYERS(LAYERS), .SCROLL_W(SW)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .pix_en(pe_o[0]), .px_x(x_o[0]), .px_y(y_o[0]),
    .hsync(hs_o[0]), .vsync(vs_o[0]), .active(act_o[0]), .frame_start(fs_o[0]),
    .scroll(sc_o[0]), .irq(irq_o[0]), .irq_ack(irq_ack));

  parallax_sequencer #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CLK_DIV(2),
    .LAYERS(LAYERS), .SCROLL_W(SW)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .pix_en(pe_o[1]), .px_x(x_o[1]), .px_y(y_o[1]),
    .hsync(hs_o[1]), .vsync(vs_o[1]), .active(act_o[1]), .frame_start(fs_o[1]),
    .scroll(sc_o[1]), .irq(irq_o[1]), .irq_ack(irq_ack));

  // Model state: enabled-edge count t, pixels elapsed in the frame n, and scroll/speed values.
  int m_t [2];
  int m_n [2];
  bit m_pe [2], m_fs [2], m_irq [2];
  int m_sc [2][LAYERS];
  int m_sp [LAYERS];
  int n_vec = 0, n_bad = 0, cyc = 0;

  bit meas = 0;
  int fs_cnt [2], last_fs [2], hs_low [2], vs_low [2], act_hi [2], pe_hi [2];

  task automatic chk(input int k, input string nm, input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL dut%0d.%s cyc=%0d got=%0d expected=%0d", k + 1, nm, cyc, a, e);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_t[k] = 0; m_n[k] = 0; m_pe[k] = 0; m_fs[k] = 0; m_irq[k] = 0;
      for (int i = 0; i < LAYERS; i++) m_sc[k][i] = 0;
    end
    for (int i = 0; i < LAYERS; i++) m_sp[i] = 0;
  endtask

  task automatic model_edge();
    bit set;
    if (reset) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      set = 0;
      m_fs[k] = 0;
      if (!enable) begin
        m_t[k] = 0; m_n[k] = 0; m_pe[k] = 0;
      end else begin
        if (m_pe[k]) begin
          m_n[k]++;
          if (m_n[k] == FRAME) begin
            m_n[k] = 0;
            m_fs[k] = 1;
            for (int i = 0; i < LAYERS; i++) m_sc[k][i] = (m_sc[k][i] + m_sp[i] + 1024) % 1024;
          end
          if (m_n[k] == (VA + VF) * HT) set = 1;
        end
        m_t[k]++;
        m_pe[k] = (m_t[k] % (k + 1)) == k;
      end
`ifdef PARALLAX_SEQ_IRQ_EN
      if (set) m_irq[k] = 1;
      else if (irq_ack) m_irq[k] = 0;
`else
      m_irq[k] = 0;
`endif
    end
    if (cfg_we) m_sp[cfg_addr] = (cfg_wdata >= 8) ? int'(cfg_wdata) - 16 : int'(cfg_wdata);
  endtask

  task automatic compare();
    int x, y;
    for (int k = 0; k < 2; k++) begin
      x = m_n[k] % HT;
      y = m_n[k] / HT;
      chk(k, "px_x", 32'(x_o[k]), x);
      chk(k, "px_y", 32'(y_o[k]), y);
      chk(k, "hsync", 32'(hs_o[k]), (x >= HA + HF && x < HA + HF + HS) ? 0 : 1);
      chk(k, "vsync", 32'(vs_o[k]), (y >= VA + VF && y < VA + VF + VS) ? 0 : 1);
      chk(k, "active", 32'(act_o[k]), (x < HA && y < VA) ? 1 : 0);
      chk(k, "pix_en", 32'(pe_o[k]), 32'(m_pe[k]));
      chk(k, "frame_start", 32'(fs_o[k]), 32'(m_fs[k]));
      chk(k, "irq", 32'(irq_o[k]), 32'(m_irq[k]));
      for (int i = 0; i < LAYERS; i++) chk(k, "scroll", 32'(sc_o[k][i*SW +: SW]), m_sc[k][i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
    cyc++;
    if (meas) begin
      for (int k = 0; k < 2; k++) begin
        if (fs_cnt[k] > 0) begin
          hs_low[k] += (hs_o[k] == 1'b0) ? 1 : 0;
          vs_low[k] += (vs_o[k] == 1'b0) ? 1 : 0;
          act_hi[k] += (act_o[k] == 1'b1) ? 1 : 0;
          pe_hi[k]  += (pe_o[k] == 1'b1) ? 1 : 0;
        end
        if (fs_o[k]) begin
          fs_cnt[k]++;
          if (fs_cnt[k] == 2) begin
            chk(k, "frame_period", cyc - last_fs[k], FRAME * (k + 1));
            chk(k, "hsync_low_clks", hs_low[k], HS * VT * (k + 1));
            chk(k, "vsync_low_clks", vs_low[k], VS * HT * (k + 1));
            chk(k, "active_clks", act_hi[k], HA * VA * (k + 1));
            chk(k, "pix_en_per_frame", pe_hi[k], FRAME);
          end
          last_fs[k] = cyc;
        end
      end
    end
  endtask

  task automatic wait_fs0(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      step();
      if (fs_o[0]) break;
    end
    if (i == budget) chk(0, "frame_start_timeout", 0, 1);
  endtask

  initial begin
    reset = 1; enable = 0; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; irq_ack = 0;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      fs_cnt[k] = 0; last_fs[k] = 0; hs_low[k] = 0; vs_low[k] = 0; act_hi[k] = 0; pe_hi[k] = 0;
    end
    #2;
    chk(0, "reset_hsync", 32'(hs_o[0]), 1);
    chk(0, "reset_pix_en", 32'(pe_o[0]), 0);
    step(); step();
    reset = 0;
    step();

    // Scroll arithmetic and frame/line timing
    enable = 1;
    cfg_we = 1; cfg_addr = 1; cfg_wdata = 4'hD;
    step();
    cfg_addr = 0; cfg_wdata = 4'h7;
    step();
    cfg_we = 0;
    meas = 1;
    wait_fs0(FRAME + 10);
    chk(0, "scroll1_f1", 32'(sc_o[0][SW +: SW]), 1021);
    chk(0, "scroll0_f1", 32'(sc_o[0][0 +: SW]), 7);
    wait_fs0(FRAME + 10);
    chk(0, "scroll1_f2", 32'(sc_o[0][SW +: SW]), 1018);
    chk(0, "scroll0_f2", 32'(sc_o[0][0 +: SW]), 14);
    for (int i = 0; i < 2 * FRAME + 20 && fs_cnt[1] < 2; i++) step();
    chk(1, "two_frames_seen", fs_cnt[1] >= 2 ? 1 : 0, 1);
    meas = 0;

    // Asynchronous reset mid-run, sampled with no clock edge in between
    for (int i = 0; i < 37; i++) step();
    #2 reset = 1;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      chk(k, "async_px_x", 32'(x_o[k]), 0);
      chk(k, "async_px_y", 32'(y_o[k]), 0);
      chk(k, "async_hsync", 32'(hs_o[k]), 1);
      chk(k, "async_vsync", 32'(vs_o[k]), 1);
      chk(k, "async_active", 32'(act_o[k]), 1);
      chk(k, "async_pix_en", 32'(pe_o[k]), 0);
      chk(k, "async_scroll", 32'(sc_o[k]), 0);
    end
    step();
    reset = 0;
    step();

    // Speed write colliding with the frame boundary, irq_ack held throughout
    irq_ack = 1;
    cfg_we = 1; cfg_addr = 2; cfg_wdata = 4'd1;
    step();
    cfg_we = 0;
    for (int i = 0; i < FRAME + 10 && m_n[0] != FRAME - 1; i++) step();
    cfg_we = 1; cfg_addr = 2; cfg_wdata = 4'd5;
    step();
    cfg_we = 0;
    chk(0, "collide_fs", 32'(fs_o[0]), 1);
    chk(0, "collide_scroll2", 32'(sc_o[0][2*SW +: SW]), 1);
    wait_fs0(FRAME + 10);
    chk(0, "next_scroll2", 32'(sc_o[0][2*SW +: SW]), 6);
    irq_ack = 0;
    for (int i = 0; i < 50; i++) step();

    // Idle hold and restart from the origin
    enable = 0;
    begin
      int fs_seen = 0;
      for (int i = 0; i < 1000; i++) begin
        step();
        fs_seen += (fs_o != 2'b00) ? 1 : 0;
      end
      chk(0, "idle_frame_starts", fs_seen, 0);
    end
    chk(0, "idle_scroll2", 32'(sc_o[0][2*SW +: SW]), 6);
    enable = 1;
    step();
    chk(0, "restart_x0", 32'(x_o[0]), 0);
    step();
    chk(0, "restart_x1", 32'(x_o[0]), 1);
    chk(1, "restart_y", 32'(y_o[1]), 0);

    // Randomized traffic
    for (int i = 0; i < 9000; i++) begin
      reset = 0;
      if (enable ? ($urandom_range(0, 599) == 0) : ($urandom_range(0, 39) == 0)) enable = ~enable;
      cfg_we    = ($urandom_range(0, 7) == 0);
      cfg_addr  = 2'($urandom);
      cfg_wdata = 4'($urandom);
      irq_ack   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 2999) == 0) reset = 1;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
